// File: rtl/mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_ctrl
// Description : Sits between the CPU and the shared data BRAM. A store to
//               TRIG_ADDR starts a one-shot dump of BRAM words 0..DEPTH-1
//               over a valid/ready stream. The CPU is stalled from then on.
//               Optional macro MEM_DUMP_CSUM_EN adds a running 32-bit
//               wrap-around checksum of the accepted beats on dump_csum.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_ctrl #(
  parameter int          ADDR_W    = 12,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] TRIG_ADDR = 32'd12
) (
  input  logic              mips_cpu_clk,
  input  logic              mips_cpu_reset_n,
  // CPU side
  input  logic [31:0]       cpu_Address,
  input  logic              cpu_MemWrite,
  input  logic              cpu_MemRead,
  input  logic [31:0]       cpu_Write_data,
  output logic [31:0]       cpu_Read_data,
  output logic              cpu_stall,
  // BRAM side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // dump stream
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [31:0]       dump_csum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [31:0]         r_dump_data;
  logic [ADDR_W-1:0]   r_dump_addr;
  logic                w_trigger;
  logic                w_accept;
  logic                w_at_last;
  logic                w_unused;

  // Reads carry no side effects; the read strobe is deliberately not consumed.
  assign w_unused  = cpu_MemRead;

  assign w_trigger = (r_state == S_IDLE) && cpu_MemWrite && (cpu_Address == TRIG_ADDR);
  assign w_accept  = (r_state == S_SEND) && dump_ready;
  // Compare before incrementing so a full 2^ADDR_W dump never wraps to word 0.
  assign w_at_last = (r_ptr == c_last_ptr);

  // State register
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) r_state <= S_IDLE;
    else                   r_state <= w_next;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    w_next        = r_state;
    mem_addr      = r_ptr;
    mem_wen       = 1'b0;
    mem_wdata     = 32'd0;
    cpu_Read_data = 32'd0;
    cpu_stall     = 1'b1;
    dump_valid    = 1'b0;
    dump_busy     = 1'b0;
    dump_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Transparent pass-through; the triggering store itself lands in BRAM.
        mem_addr      = cpu_Address[ADDR_W+1:2];
        mem_wen       = cpu_MemWrite;
        mem_wdata     = cpu_Write_data;
        cpu_Read_data = mem_rdata;
        cpu_stall     = 1'b0;
        if (w_trigger) w_next = S_RD;
      end
      S_RD: begin
        dump_busy = 1'b1;
        w_next    = S_WT;
      end
      S_WT: begin
        dump_busy = 1'b1;
        w_next    = S_SEND;
      end
      S_SEND: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) w_next = w_at_last ? S_DONE : S_RD;
      end
      S_DONE: begin
        dump_done = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word pointer and beat capture; beat registers only change in WT, so they
  // are held for as long as SEND waits on dump_ready.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      r_ptr       <= '0;
      r_dump_data <= 32'd0;
      r_dump_addr <= '0;
    end else begin
      if (w_trigger) begin
        r_ptr <= '0;
      end else if (w_accept && !w_at_last) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (r_state == S_WT) begin
        r_dump_data <= mem_rdata;
        r_dump_addr <= r_ptr;
      end
    end
  end

  assign dump_data = r_dump_data;
  assign dump_addr = r_dump_addr;
  assign dump_last = (r_state == S_SEND) && w_at_last;

`ifdef MEM_DUMP_CSUM_EN
  logic [31:0] r_csum;

  // Running sum of every accepted beat; frozen once DONE is reached.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) r_csum <= 32'd0;
    else if (w_accept)     r_csum <= r_csum + r_dump_data;
  end

  assign dump_csum = r_csum;
`else
  assign dump_csum = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dump_ctrl
// Description : Directed self-checking bench for mem_dump_ctrl with a
//               synchronous-read BRAM model. Honors MEM_DUMP_CSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_dump_ctrl;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  logic              mips_cpu_clk = 1'b0;
  logic              mips_cpu_reset_n;
  logic [31:0]       cpu_Address;
  logic              cpu_MemWrite;
  logic              cpu_MemRead;
  logic [31:0]       cpu_Write_data;
  logic [31:0]       cpu_Read_data;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [31:0]       dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_last;
  logic              dump_busy;
  logic              dump_done;
  logic [31:0]       dump_csum;

  always #5 mips_cpu_clk = ~mips_cpu_clk;

  mem_dump_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TRIG_ADDR(32'd12)) dut (
    .mips_cpu_clk     (mips_cpu_clk),
    .mips_cpu_reset_n (mips_cpu_reset_n),
    .cpu_Address      (cpu_Address),
    .cpu_MemWrite     (cpu_MemWrite),
    .cpu_MemRead      (cpu_MemRead),
    .cpu_Write_data   (cpu_Write_data),
    .cpu_Read_data    (cpu_Read_data),
    .cpu_stall        (cpu_stall),
    .mem_addr         (mem_addr),
    .mem_wen          (mem_wen),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .dump_valid       (dump_valid),
    .dump_ready       (dump_ready),
    .dump_data        (dump_data),
    .dump_addr        (dump_addr),
    .dump_last        (dump_last),
    .dump_busy        (dump_busy),
    .dump_done        (dump_done),
    .dump_csum        (dump_csum)
  );

  // Synchronous-read BRAM, read-before-write
  logic [31:0] bram     [0:DEPTH-1];
  logic [31:0] exp_word [0:DEPTH-1];

  always @(posedge mips_cpu_clk) begin
    if (mem_wen) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Ready pattern: 0 = always ready, 1 = ready one cycle in four
  int ready_mode = 0;
  int cyc = 0;
  initial begin
    dump_ready = 1'b0;
    forever begin
      @(posedge mips_cpu_clk);
      #1;
      cyc++;
      dump_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
    end
  end

  // Beat monitor, sampled mid-cycle; acceptance happens at the next rising edge.
  int                beat_n;
  int                bad_addr, bad_data, bad_last, bad_hold;
  logic              prev_wait;
  logic [31:0]       hold_data;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_last;

  always @(negedge mips_cpu_clk) begin
    if (!mips_cpu_reset_n) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && (!dump_valid || dump_data !== hold_data ||
                        dump_addr !== hold_addr || dump_last !== hold_last))
        bad_hold++;
      if (dump_valid && dump_ready) begin
        if (beat_n >= DEPTH) begin
          bad_addr++;
        end else begin
          if (dump_addr !== beat_n[ADDR_W-1:0]) bad_addr++;
          if (dump_data !== exp_word[beat_n])   bad_data++;
          if (dump_last !== (beat_n == DEPTH-1)) bad_last++;
        end
        beat_n++;
      end
      prev_wait = dump_valid && !dump_ready;
      hold_data = dump_data;
      hold_addr = dump_addr;
      hold_last = dump_last;
    end
  end

  task automatic cpu_idle();
    cpu_Address    = 32'd0;
    cpu_MemWrite   = 1'b0;
    cpu_MemRead    = 1'b0;
    cpu_Write_data = 32'd0;
  endtask

  task automatic mon_clear();
    beat_n   = 0;
    bad_addr = 0;
    bad_data = 0;
    bad_last = 0;
    bad_hold = 0;
  endtask

  // Issue one store, held for one clock edge; returns at posedge+1.
  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    cpu_Address    = a;
    cpu_MemWrite   = 1'b1;
    cpu_Write_data = d;
    @(posedge mips_cpu_clk);
    #1;
    cpu_idle();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge mips_cpu_clk);
      #1;
      if (dump_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    #2;
    mips_cpu_reset_n = 1'b0;
    repeat (3) @(posedge mips_cpu_clk);
    #1;
  endtask

  task automatic end_of_dump_checks(input string tag);
    check({tag, "_beats"},    32'(beat_n), 32'd4096);
    check({tag, "_bad_addr"}, 32'(bad_addr), 32'd0);
    check({tag, "_bad_data"}, 32'(bad_data), 32'd0);
    check({tag, "_bad_last"}, 32'(bad_last), 32'd0);
    check({tag, "_done"},     32'(dump_done), 32'd1);
    check({tag, "_stall"},    32'(cpu_stall), 32'd1);
    check({tag, "_busy"},     32'(dump_busy), 32'd0);
    check({tag, "_valid"},    32'(dump_valid), 32'd0);
  endtask

  bit ok;

  initial begin
    cpu_idle();
    mon_clear();
    prev_wait        = 1'b0;
    mips_cpu_reset_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i]     = 32'(i * 3);
      exp_word[i] = 32'(i * 3);
    end
    repeat (3) @(posedge mips_cpu_clk);
    #1;

    // Reset state
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_busy",  32'(dump_busy), 32'd0);
    check("rst_done",  32'(dump_done), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_last",  32'(dump_last), 32'd0);
    check("rst_data",  dump_data, 32'd0);
    check("rst_addr",  32'(dump_addr), 32'd0);
    check("rst_csum",  dump_csum, 32'd0);

    mips_cpu_reset_n = 1'b1;
    @(posedge mips_cpu_clk);
    #1;

    // Plain store passes through without triggering
    cpu_Address    = 32'h40;
    cpu_MemWrite   = 1'b1;
    cpu_Write_data = 32'hDEADBEEF;
    #2;
    check("st40_wen",   32'(mem_wen), 32'd1);
    check("st40_addr",  32'(mem_addr), 32'h10);
    check("st40_wdata", mem_wdata, 32'hDEADBEEF);
    check("st40_stall", 32'(cpu_stall), 32'd0);
    @(posedge mips_cpu_clk);
    #1;
    cpu_idle();
    check("st40_land", bram[16], 32'hDEADBEEF);
    check("st40_busy", 32'(dump_busy), 32'd0);

    // CPU read path in IDLE
    cpu_Address = 32'h40;
    cpu_MemRead = 1'b1;
    @(posedge mips_cpu_clk);
    #1;
    check("rd40_data", cpu_Read_data, 32'hDEADBEEF);
    cpu_idle();
    cpu_store(32'h40, 32'd48);

    // Read of the trigger address, store to a neighbour: no trigger
    cpu_Address = 32'd12;
    cpu_MemRead = 1'b1;
    #2;
    check("rd12_wen", 32'(mem_wen), 32'd0);
    @(posedge mips_cpu_clk);
    #1;
    cpu_idle();
    check("rd12_busy", 32'(dump_busy), 32'd0);
    cpu_store(32'd8, 32'd6);
    check("st8_busy",  32'(dump_busy), 32'd0);
    check("st8_stall", 32'(cpu_stall), 32'd0);

    // Dump 1: data i*3, word 3 overwritten by the trigger store, always ready
    exp_word[3] = 32'd0;
    mon_clear();
    cpu_Address    = 32'd12;
    cpu_MemWrite   = 1'b1;
    cpu_Write_data = 32'd0;
    #2;
    check("trig_wen",  32'(mem_wen), 32'd1);
    check("trig_addr", 32'(mem_addr), 32'd3);
    @(posedge mips_cpu_clk);
    #1;
    cpu_idle();
    check("trig_busy",  32'(dump_busy), 32'd1);
    check("trig_stall", 32'(cpu_stall), 32'd1);
    check("trig_rdata", cpu_Read_data, 32'd0);
    wait_done(20000, ok);
    check("d1_timeout", 32'(ok), 32'd1);
    end_of_dump_checks("d1");
`ifdef MEM_DUMP_CSUM_EN
    check("d1_csum", dump_csum, 32'd25159671);
`else
    check("d1_csum", dump_csum, 32'd0);
`endif

    // DONE is terminal: a fresh trigger store is ignored
    cpu_Address    = 32'd12;
    cpu_MemWrite   = 1'b1;
    cpu_Write_data = 32'h5A5A5A5A;
    #2;
    check("done_wen", 32'(mem_wen), 32'd0);
    repeat (10) @(posedge mips_cpu_clk);
    #1;
    cpu_idle();
    check("done_hold",  32'(dump_done), 32'd1);
    check("done_beats", 32'(beat_n), 32'd4096);

    // Dump 2: all ones except word 3, ready one cycle in four
    do_reset();
    check("rst2_done", 32'(dump_done), 32'd0);
    check("rst2_csum", dump_csum, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      bram[i]     = 32'd1;
      exp_word[i] = 32'd1;
    end
    exp_word[3] = 32'd0;
    ready_mode  = 1;
    mon_clear();
    mips_cpu_reset_n = 1'b1;
    @(posedge mips_cpu_clk);
    #1;
    cpu_store(32'd12, 32'd0);
    wait_done(60000, ok);
    check("d2_timeout", 32'(ok), 32'd1);
    end_of_dump_checks("d2");
    check("d2_hold", 32'(bad_hold), 32'd0);
`ifdef MEM_DUMP_CSUM_EN
    check("d2_csum", dump_csum, 32'd4095);
`else
    check("d2_csum", dump_csum, 32'd0);
`endif

    // Dump 3: reset while beat 100 is on the stream, then restart
    do_reset();
    ready_mode = 0;
    mon_clear();
    mips_cpu_reset_n = 1'b1;
    @(posedge mips_cpu_clk);
    #1;
    cpu_store(32'd12, 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (dump_valid && dump_addr == ADDR_W'(100)) begin
        ok = 1'b1;
        break;
      end
      @(posedge mips_cpu_clk);
      #1;
    end
    check("b100_reached", 32'(ok), 32'd1);
    #2;
    mips_cpu_reset_n = 1'b0;
    #1;
    check("abort_valid", 32'(dump_valid), 32'd0);
    check("abort_busy",  32'(dump_busy), 32'd0);
    check("abort_stall", 32'(cpu_stall), 32'd0);
    check("abort_addr",  32'(dump_addr), 32'd0);
    repeat (3) @(posedge mips_cpu_clk);
    #1;
    check("abort_beats", 32'(beat_n), 32'd100);
    mon_clear();
    mips_cpu_reset_n = 1'b1;
    @(posedge mips_cpu_clk);
    #1;
    cpu_store(32'd12, 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dump_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge mips_cpu_clk);
      #1;
    end
    check("restart_valid", 32'(ok), 32'd1);
    check("restart_addr",  32'(dump_addr), 32'd0);
    check("restart_data",  dump_data, 32'd1);
    wait_done(20000, ok);
    check("d3_timeout", 32'(ok), 32'd1);
    end_of_dump_checks("d3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_dump_ctrl.md
MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning word-address width of the shared data BRAM.
REQ-002 SHALL have parameter DEPTH, default 4096, meaning number of 32-bit words dumped (0..DEPTH-1).
REQ-003 SHALL have parameter TRIG_ADDR, default 32'd12, meaning CPU byte address whose store triggers the dump.
REQ-004 SHALL have ports: mips_cpu_clk  in  1  sole clock; mips_cpu_reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have CPU-side ports: cpu_Address in 32; cpu_MemWrite in 1; cpu_MemRead in 1; cpu_Write_data in 32; cpu_Read_data out 32; cpu_stall out 1 (CPU holds state while high).
REQ-006 SHALL have BRAM-side ports: mem_addr out ADDR_W (word address); mem_wen out 1; mem_wdata out 32; mem_rdata in 32 (valid one cycle after mem_addr).
REQ-007 SHALL have dump-stream ports: dump_valid out 1; dump_ready in 1; dump_data out 32; dump_addr out ADDR_W; dump_last out 1; dump_busy out 1; dump_done out 1; dump_csum out 32.

Function
REQ-008 SHALL implement states IDLE, RD, WT, SEND, DONE.
REQ-009 IDLE: mem_addr=cpu_Address[ADDR_W+1:2], mem_wen=cpu_MemWrite, mem_wdata=cpu_Write_data, cpu_Read_data=mem_rdata, cpu_stall=0.
REQ-010 Trigger = IDLE && cpu_MemWrite && cpu_Address==TRIG_ADDR; the triggering store SHALL reach the BRAM in that same cycle; next state RD, word pointer ptr=0.
REQ-011 Stores to other addresses and all reads SHALL never trigger; cpu_MemRead alone SHALL never alter state.
REQ-012 RD: mem_addr=ptr, mem_wen=0; next state WT unconditionally.
REQ-013 WT: register mem_rdata into dump_data, ptr into dump_addr; next state SEND.
REQ-014 SEND: dump_valid=1; dump_data/dump_addr/dump_last SHALL stay stable while dump_valid && !dump_ready.
REQ-015 SEND with dump_ready=1: if ptr==DEPTH-1 go DONE, else ptr=ptr+1 and go RD; minimum 3 cycles per word.
REQ-016 dump_last SHALL be 1 exactly while in SEND with ptr==DEPTH-1.
REQ-017 dump_ready SHALL be ignored outside SEND.
REQ-018 In RD, WT, SEND, DONE: cpu_stall=1, mem_wen=0, CPU requests ignored, cpu_Read_data=0.
REQ-019 dump_busy=1 in RD, WT, SEND; dump_done=1 only in DONE.
REQ-020 DONE SHALL be terminal; only reset leaves it (one dump per reset).
REQ-021 ptr SHALL be ADDR_W bits; DEPTH==2^ADDR_W SHALL complete without wrap to word 0 being re-sent.

Reset
REQ-022 mips_cpu_reset_n low SHALL asynchronously force IDLE, ptr=0, dump_valid=0, dump_last=0, dump_busy=0, dump_done=0, dump_data=0, dump_addr=0, dump_csum=0, cpu_stall=0.
REQ-023 Reset asserted mid-dump SHALL abort the stream with no further beats; after release the block SHALL behave as after power-up and accept a new trigger.

Configuration
REQ-024 Macro MEM_DUMP_CSUM_EN defined: dump_csum SHALL accumulate the 32-bit wrap-around sum of every accepted beat's dump_data, final value held in DONE.
REQ-025 Macro MEM_DUMP_CSUM_EN undefined: dump_csum SHALL be constant 0 and no accumulator SHALL be synthesized; all other behaviour identical.

Verification
REQ-026 Store 0xDEADBEEF to 0x40 in IDLE -> mem_wen=1, mem_addr=0x10, no trigger, cpu_stall=0.
REQ-027 Preload word i = i*3, store 0 to address 12, dump_ready=1 -> 4096 beats, dump_addr 0..4095 ascending, word 3 = 0, dump_last only on addr 4095, then dump_done=1, cpu_stall=1.
REQ-028 dump_ready toggling 1-of-4 cycles -> each beat's data/addr held stable until accepted; no beat lost or duplicated.
REQ-029 mips_cpu_reset_n low during beat 100 -> dump_valid=0 immediately; after release, trigger again -> stream restarts at dump_addr 0.
REQ-030 MEM_DUMP_CSUM_EN defined, all words 0x00000001 except word 3 = 0 -> dump_csum=4095 in DONE; undefined -> dump_csum=0.
REQ-031 cpu_MemRead to address 12 and store to address 8 -> no trigger, dump_busy stays 0.
